// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states and
// datapath mux/ALU select values.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ALU_A_RS1   = 2'd0;
    localparam logic [1:0] ALU_A_PC    = 2'd1;
    localparam logic [1:0] ALU_A_OLDPC = 2'd2;
    localparam logic [1:0] ALU_A_ZERO  = 2'd3;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_OP_ADD = 2'd0;
    localparam logic [1:0] ALU_OP_BR  = 2'd1;
    localparam logic [1:0] ALU_OP_R   = 2'd2;
    localparam logic [1:0] ALU_OP_I   = 2'd3;

    function automatic logic is_legal_op(logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts cycles a memory request waits without completion; expire flags the last
// allowed waiting cycle.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= 8'd0;
        end else if (inc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expire = inc && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb
// and decodes per-cycle datapath strobes.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_error,
    output logic [2:0] state_dbg
);

    state_e state_q;
    logic   illegal_q;
    logic   bus_error_q;
    logic   expire;

    // funct3 only feeds the ALU decoder downstream; sequencing ignores it.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    // mem_req is low outside FETCH/MEM, so this also clears on every state change.
    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!mem_req || mem_ready),
        .inc    (mem_req && !mem_ready),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        state_q <= StDecode;
                    end else if (expire) begin
                        bus_error_q <= 1'b1;
                        state_q     <= StHalt;
                    end
                end
                StDecode: begin
                    if (is_legal_op(opcode)) begin
                        state_q <= StExec;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
                    end
                end
                StExec: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_q <= StMem;
                        OP_BRANCH:         state_q <= StFetch;
                        default:           state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        state_q <= (opcode == OP_LOAD) ? StWb : StFetch;
                    end else if (expire) begin
                        bus_error_q <= 1'b1;
                        state_q     <= StHalt;
                    end
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StHalt;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_RS2;
        alu_op    = ALU_OP_ADD;
        illegal   = 1'b0;
        bus_error = 1'b0;
        state_dbg = 3'd0;
        if (!reset) begin
            illegal   = illegal_q;
            bus_error = bus_error_q;
            state_dbg = state_q;
            unique case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_a_sel = ALU_A_PC;
                    alu_b_sel = ALU_B_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                StDecode: begin
                    // Precompute old_pc + imm as the branch/JAL target.
                    alu_a_sel = ALU_A_OLDPC;
                    alu_b_sel = ALU_B_IMM;
                end
                StExec: begin
                    case (opcode)
                        OP_R: alu_op = ALU_OP_R;
                        OP_IMM: begin
                            alu_b_sel = ALU_B_IMM;
                            alu_op    = ALU_OP_I;
                        end
                        OP_LOAD, OP_STORE: alu_b_sel = ALU_B_IMM;
                        OP_BRANCH: begin
                            alu_op   = ALU_OP_BR;
                            pc_write = br_taken;
                            pc_src   = 1'b1;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        OP_JALR: begin
                            alu_b_sel = ALU_B_IMM;
                            pc_write  = 1'b1;
                        end
                        OP_LUI: begin
                            alu_a_sel = ALU_A_ZERO;
                            alu_b_sel = ALU_B_IMM;
                        end
                        OP_AUIPC: begin
                            alu_a_sel = ALU_A_OLDPC;
                            alu_b_sel = ALU_B_IMM;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_STORE);
                end
                StWb: begin
                    reg_write = 1'b1;
                    case (opcode)
                        OP_LOAD:         wb_sel = WB_MEM;
                        OP_JAL, OP_JALR: wb_sel = WB_PC4;
                        default:         wb_sel = WB_ALU;
                    endcase
                end
                StHalt:  ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each step queues the expected output vector,
// the value is popped and compared mid-cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] wb_sel, alu_a_sel, alu_b_sel, alu_op;
    logic       illegal, bus_error;
    logic [2:0] state_dbg;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irw, pcw, pcs, rw;
        logic [1:0] wb, a, b, op;
        logic       ill, berr;
    } vec_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       br;
        logic [6:0] opc;
        vec_t       exp;
    } stim_t;

    vec_t obs;
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] BAD = 7'b1111111;

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct3    (funct3),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .bus_error (bus_error),
        .state_dbg (state_dbg)
    );

    assign obs = {state_dbg, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                  wb_sel, alu_a_sel, alu_b_sel, alu_op, illegal, bus_error};

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [2:0] st, logic req, logic we, logic io, logic irw,
                                logic pcw, logic pcs, logic rw, logic [1:0] wb,
                                logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                logic ill, logic berr);
        mk = {st, req, we, io, irw, pcw, pcs, rw, wb, a, b, op, ill, berr};
    endfunction

    function automatic vec_t v_zero();
        v_zero = '0;
    endfunction
    function automatic vec_t v_fw();  // fetch waiting
        v_fw = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0);
    endfunction
    function automatic vec_t v_fr();  // fetch completing
        v_fr = mk(3'd0, 1, 0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0);
    endfunction
    function automatic vec_t v_dec();
        v_dec = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 0);
    endfunction
    function automatic vec_t v_ex(logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                  logic pcw, logic pcs);
        v_ex = mk(3'd2, 0, 0, 0, 0, pcw, pcs, 0, 2'd0, a, b, op, 0, 0);
    endfunction
    function automatic vec_t v_mem(logic we);
        v_mem = mk(3'd3, 1, we, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    endfunction
    function automatic vec_t v_wb(logic [1:0] wb);
        v_wb = mk(3'd4, 0, 0, 0, 0, 0, 0, 1, wb, 2'd0, 2'd0, 2'd0, 0, 0);
    endfunction
    function automatic vec_t v_halt(logic ill, logic berr);
        v_halt = mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, ill, berr);
    endfunction

    task automatic test_reset();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, ADD, v_zero()});
        plan.push_back('{1'b1, 1'b1, 1'b1, ADD, v_zero()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_fw()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b1, 1'b0, ADD, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_fr()});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_dec()});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_ex(2'd0, 2'd0, 2'd2, 0, 0)});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_wb(2'd0)});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_fw()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL add step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, LW, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b0, LW, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, LW, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, LW, v_ex(2'd0, 2'd1, 2'd0, 0, 0)});
        for (int k = 0; k < 3; k++) plan.push_back('{1'b0, 1'b0, 1'b0, LW, v_mem(1'b0)});
        plan.push_back('{1'b0, 1'b1, 1'b0, LW, v_mem(1'b0)});
        plan.push_back('{1'b0, 1'b0, 1'b0, LW, v_wb(2'd1)});
        plan.push_back('{1'b0, 1'b0, 1'b0, LW, v_fw()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, BEQ, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b1, BEQ, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b1, BEQ, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, BEQ, v_ex(2'd0, 2'd0, 2'd1, 0, 1)});
        plan.push_back('{1'b0, 1'b1, 1'b0, BEQ, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, BEQ, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b1, BEQ, v_ex(2'd0, 2'd0, 2'd1, 1, 1)});
        plan.push_back('{1'b0, 1'b0, 1'b0, BEQ, v_fw()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exec_types();
        stim_t      plan[$];
        vec_t       e;
        logic [6:0] ops[5] = '{ADDI, LUI, AUIPC, JALR, JAL};
        vec_t       exs[5];
        logic [1:0] wbs[5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
        exs[0] = v_ex(2'd0, 2'd1, 2'd3, 0, 0);
        exs[1] = v_ex(2'd3, 2'd1, 2'd0, 0, 0);
        exs[2] = v_ex(2'd2, 2'd1, 2'd0, 0, 0);
        exs[3] = v_ex(2'd0, 2'd1, 2'd0, 1, 0);
        exs[4] = v_ex(2'd0, 2'd0, 2'd0, 1, 1);
        plan.push_back('{1'b1, 1'b0, 1'b0, ADDI, v_zero()});
        for (int k = 0; k < 5; k++) begin
            plan.push_back('{1'b0, 1'b1, 1'b0, ops[k], v_fr()});
            plan.push_back('{1'b0, 1'b0, 1'b0, ops[k], v_dec()});
            plan.push_back('{1'b0, 1'b0, 1'b0, ops[k], exs[k]});
            plan.push_back('{1'b0, 1'b0, 1'b0, ops[k], v_wb(wbs[k])});
        end
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL exec_types step %0d op %b: got %h expected %h",
                         i, plan[i].opc, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, SW, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b0, SW, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_ex(2'd0, 2'd1, 2'd0, 0, 0)});
        plan.push_back('{1'b0, 1'b1, 1'b0, SW, v_mem(1'b1)});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_ex(2'd0, 2'd0, 2'd2, 0, 0)});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_wb(2'd0)});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, BAD, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b0, BAD, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, BAD, v_dec()});
        for (int k = 0; k < 10; k++)
            plan.push_back('{1'b0, 1'(k % 2), 1'b1, BAD, v_halt(1'b1, 1'b0)});
        plan.push_back('{1'b1, 1'b0, 1'b0, ADD, v_zero()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_fw()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, ADD, v_zero()});
        for (int k = 0; k < 16; k++) plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_fw()});
        for (int k = 0; k < 3; k++)
            plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_halt(1'b0, 1'b1)});
        plan.push_back('{1'b1, 1'b0, 1'b0, ADD, v_zero()});
        for (int k = 0; k < 15; k++) plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_fw()});
        plan.push_back('{1'b0, 1'b1, 1'b0, ADD, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, ADD, v_ex(2'd0, 2'd0, 2'd2, 0, 0)});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_store();
        stim_t plan[$];
        vec_t  e;
        plan.push_back('{1'b1, 1'b0, 1'b0, SW, v_zero()});
        plan.push_back('{1'b0, 1'b1, 1'b0, SW, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_dec()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_ex(2'd0, 2'd1, 2'd0, 0, 0)});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_mem(1'b1)});
        plan.push_back('{1'b1, 1'b1, 1'b0, SW, v_zero()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_fw()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_fw()});
        plan.push_back('{1'b0, 1'b1, 1'b0, SW, v_fr()});
        plan.push_back('{1'b0, 1'b0, 1'b0, SW, v_dec()});
        foreach (plan[i]) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy;
            br_taken = plan[i].br; opcode = plan[i].opc;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_store step %0d: got %h expected %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_exec_types();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
